// File: rtl/ram_dp_arb.sv
// Initialiser plus two independent round-robin arbiters (write and read ports) in front
// of a simple dual-port block RAM with one cycle of read latency.
module ram_dp_arb #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 9,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    output logic                 init_busy,

    input  logic                 a_wr_req,
    input  logic [ADDRWIDTH-1:0] a_wr_addr,
    input  logic [DATAWIDTH-1:0] a_wr_data,
    output logic                 a_wr_ack,
    input  logic                 b_wr_req,
    input  logic [ADDRWIDTH-1:0] b_wr_addr,
    input  logic [DATAWIDTH-1:0] b_wr_data,
    output logic                 b_wr_ack,

    input  logic                 a_rd_req,
    input  logic [ADDRWIDTH-1:0] a_rd_addr,
    output logic                 a_rd_ack,
    output logic                 a_rd_valid,
    output logic [DATAWIDTH-1:0] a_rd_data,
    input  logic                 b_rd_req,
    input  logic [ADDRWIDTH-1:0] b_rd_addr,
    output logic                 b_rd_ack,
    output logic                 b_rd_valid,
    output logic [DATAWIDTH-1:0] b_rd_data,

    output logic                 ram_enable,
    output logic                 ram_we,
    output logic [ADDRWIDTH-1:0] ram_wr_addr,
    output logic [DATAWIDTH-1:0] ram_wr_data,
    output logic [ADDRWIDTH-1:0] ram_rd_addr,
    input  logic [DATAWIDTH-1:0] ram_rd_data
);

    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {SEL_A, SEL_B} sel_t;

    state_t                 state, state_next;
    logic [ADDRWIDTH-1:0]   init_cnt, init_cnt_next;
    sel_t                   wr_last, rd_last;

    logic run_ok;
    logic wr_grant_a, wr_grant_b;
    logic rd_grant_a, rd_grant_b;

    // Grants use only the live requests and registered state, so acks never loop back.
    always_comb begin
        run_ok     = !reset && (state == RUN) && !clear;
        wr_grant_a = run_ok && a_wr_req && (!b_wr_req || wr_last == SEL_B);
        wr_grant_b = run_ok && b_wr_req && (!a_wr_req || wr_last == SEL_A);
        rd_grant_a = run_ok && a_rd_req && (!b_rd_req || rd_last == SEL_B);
        rd_grant_b = run_ok && b_rd_req && (!a_rd_req || rd_last == SEL_A);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        case (state)
            INIT: begin
                if (clear) begin
                    init_cnt_next = '0;
                end else if (init_cnt == '1) begin
                    state_next    = RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt + ADDRWIDTH'(1);
                end
            end
            RUN: begin
                if (clear) begin
                    state_next    = INIT;
                    init_cnt_next = '0;
                end
            end
            default: begin
                state_next    = INIT;
                init_cnt_next = '0;
            end
        endcase
    end

    // RAM port muxing: the init sweep owns the write port, otherwise the write winner does.
    always_comb begin
        ram_we      = 1'b0;
        ram_wr_addr = a_wr_addr;
        ram_wr_data = a_wr_data;
        if (!reset && state == INIT) begin
            ram_we      = 1'b1;
            ram_wr_addr = init_cnt;
            ram_wr_data = INIT_VALUE;
        end else if (wr_grant_a) begin
            ram_we      = 1'b1;
        end else if (wr_grant_b) begin
            ram_we      = 1'b1;
            ram_wr_addr = b_wr_addr;
            ram_wr_data = b_wr_data;
        end
    end

    assign ram_rd_addr = rd_grant_b ? b_rd_addr : a_rd_addr;
    assign ram_enable  = 1'b1;
    assign init_busy   = (state == INIT);

    assign a_wr_ack = wr_grant_a;
    assign b_wr_ack = wr_grant_b;
    assign a_rd_ack = rd_grant_a;
    assign b_rd_ack = rd_grant_b;

    assign a_rd_data = ram_rd_data;
    assign b_rd_data = ram_rd_data;

    // Round-robin history starts at B so A wins the first contention on each port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_last    <= SEL_B;
            rd_last    <= SEL_B;
            a_rd_valid <= 1'b0;
            b_rd_valid <= 1'b0;
        end else begin
            if (wr_grant_a)
                wr_last <= SEL_A;
            else if (wr_grant_b)
                wr_last <= SEL_B;
            if (rd_grant_a)
                rd_last <= SEL_A;
            else if (rd_grant_b)
                rd_last <= SEL_B;
            a_rd_valid <= rd_grant_a;
            b_rd_valid <= rd_grant_b;
        end
    end

endmodule

// File: tb/tb_ram_dp_arb.sv
// Directed bench for ram_dp_arb with a small behavioural block RAM attached to its RAM ports.
module tb_ram_dp_arb;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam logic [DW-1:0] INITV = 8'hA5;

    logic          clk = 1'b0;
    logic          reset, clear, init_busy;
    logic          a_wr_req, b_wr_req, a_wr_ack, b_wr_ack;
    logic [AW-1:0] a_wr_addr, b_wr_addr;
    logic [DW-1:0] a_wr_data, b_wr_data;
    logic          a_rd_req, b_rd_req, a_rd_ack, b_rd_ack, a_rd_valid, b_rd_valid;
    logic [AW-1:0] a_rd_addr, b_rd_addr;
    logic [DW-1:0] a_rd_data, b_rd_data;
    logic          ram_enable, ram_we;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    ram_dp_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .INIT_VALUE(INITV)) dut (
        .clk(clk), .reset(reset), .clear(clear), .init_busy(init_busy),
        .a_wr_req(a_wr_req), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_ack(a_wr_ack),
        .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_ack(b_wr_ack),
        .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_ack(a_rd_ack),
        .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data),
        .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_ack(b_rd_ack),
        .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data),
        .ram_enable(ram_enable), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // Behavioural RAM: registered read returns the pre-write contents on a same-address collision.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_we)
                mem[ram_wr_addr] <= ram_wr_data;
            ram_rd_data <= mem[ram_rd_addr];
        end
    end

    typedef struct {
        logic          awr; logic [AW-1:0] awa; logic [DW-1:0] awd;
        logic          bwr; logic [AW-1:0] bwa; logic [DW-1:0] bwd;
        logic          ard; logic [AW-1:0] ara;
        logic          brd; logic [AW-1:0] bra;
        logic          eAwAck, eBwAck, eWe;
        logic [AW-1:0] eWa;  logic [DW-1:0] eWd;
        logic          eArAck, eBrAck, eAv, eBv;
        logic [DW-1:0] eRd;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(
        input logic awr, input logic [AW-1:0] awa, input logic [DW-1:0] awd,
        input logic bwr, input logic [AW-1:0] bwa, input logic [DW-1:0] bwd,
        input logic ard, input logic [AW-1:0] ara, input logic brd, input logic [AW-1:0] bra,
        input logic eAwAck, input logic eBwAck, input logic eWe,
        input logic [AW-1:0] eWa, input logic [DW-1:0] eWd,
        input logic eArAck, input logic eBrAck, input logic eAv, input logic eBv,
        input logic [DW-1:0] eRd);
        vec_t v;
        v.awr = awr; v.awa = awa; v.awd = awd;
        v.bwr = bwr; v.bwa = bwa; v.bwd = bwd;
        v.ard = ard; v.ara = ara; v.brd = brd; v.bra = bra;
        v.eAwAck = eAwAck; v.eBwAck = eBwAck; v.eWe = eWe; v.eWa = eWa; v.eWd = eWd;
        v.eArAck = eArAck; v.eBrAck = eBrAck; v.eAv = eAv; v.eBv = eBv; v.eRd = eRd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        a_wr_req = v.awr; a_wr_addr = v.awa; a_wr_data = v.awd;
        b_wr_req = v.bwr; b_wr_addr = v.bwa; b_wr_data = v.bwd;
        a_rd_req = v.ard; a_rd_addr = v.ara;
        b_rd_req = v.brd; b_rd_addr = v.bra;
    endtask

    task automatic idleInputs();
        a_wr_req = 0; b_wr_req = 0; a_rd_req = 0; b_rd_req = 0;
        a_wr_addr = '0; b_wr_addr = '0; a_rd_addr = '0; b_rd_addr = '0;
        a_wr_data = '0; b_wr_data = '0;
    endtask

    // A reads every address back to back; each must return the init value one cycle later.
    task automatic readAllInit(input string tag);
        for (int i = 0; i <= (1 << AW); i++) begin
            idleInputs();
            a_rd_req  = (i < (1 << AW));
            a_rd_addr = AW'(i);
            #1;
            if (i < (1 << AW))
                checkOutput({tag, " a_rd_ack"}, 32'(a_rd_ack), 32'd1);
            if (i > 0) begin
                checkOutput({tag, " a_rd_valid"}, 32'(a_rd_valid), 32'd1);
                checkOutput({tag, " a_rd_data"}, 32'(a_rd_data), 32'(INITV));
            end
            tick();
        end
        idleInputs();
    endtask

    int busyCycles;

    initial begin
        // Stimulus vectors for the RUN phase right after the first sweep
        vecs[0]  = mk(1,1,8'h10, 1,2,8'h20, 0,0, 0,0,  1,0,1, 1,8'h10, 0,0, 0,0,8'h00);
        vecs[1]  = mk(1,7,8'h17, 1,2,8'h20, 0,0, 0,0,  0,1,1, 2,8'h20, 0,0, 0,0,8'h00);
        vecs[2]  = mk(1,7,8'h17, 1,4,8'h21, 0,0, 0,0,  1,0,1, 7,8'h17, 0,0, 0,0,8'h00);
        vecs[3]  = mk(1,6,8'h12, 1,4,8'h21, 0,0, 0,0,  0,1,1, 4,8'h21, 0,0, 0,0,8'h00);
        vecs[4]  = mk(1,3,8'h11, 0,0,8'h00, 0,0, 0,0,  1,0,1, 3,8'h11, 0,0, 0,0,8'h00);
        vecs[5]  = mk(0,0,8'h00, 0,0,8'h00, 0,0, 1,3,  0,0,0, 0,8'h00, 0,1, 0,0,8'h00);
        vecs[6]  = mk(0,0,8'h00, 0,0,8'h00, 0,0, 0,0,  0,0,0, 0,8'h00, 0,0, 0,1,8'h11);
        vecs[7]  = mk(1,5,8'h22, 0,0,8'h00, 0,0, 1,5,  1,0,1, 5,8'h22, 0,1, 0,0,8'h00);
        vecs[8]  = mk(0,0,8'h00, 0,0,8'h00, 0,0, 1,5,  0,0,0, 0,8'h00, 0,1, 0,1,8'hA5);
        vecs[9]  = mk(0,0,8'h00, 0,0,8'h00, 0,0, 0,0,  0,0,0, 0,8'h00, 0,0, 0,1,8'h22);
        vecs[10] = mk(0,0,8'h00, 0,0,8'h00, 1,1, 1,2,  0,0,0, 0,8'h00, 1,0, 0,0,8'h00);
        vecs[11] = mk(0,0,8'h00, 0,0,8'h00, 1,4, 1,2,  0,0,0, 0,8'h00, 0,1, 1,0,8'h10);
        vecs[12] = mk(0,0,8'h00, 0,0,8'h00, 1,4, 0,0,  0,0,0, 0,8'h00, 1,0, 0,1,8'h20);
        vecs[13] = mk(0,0,8'h00, 0,0,8'h00, 1,7, 0,0,  0,0,0, 0,8'h00, 1,0, 1,0,8'h21);
        vecs[14] = mk(0,0,8'h00, 0,0,8'h00, 0,0, 0,0,  0,0,0, 0,8'h00, 0,0, 1,0,8'h17);

        // Reset cycle: acks and write enable are forced low even with a request present
        idleInputs();
        clear    = 0;
        reset    = 1;
        a_wr_req = 1;
        #1;
        checkOutput("reset a_wr_ack", 32'(a_wr_ack), 32'd0);
        checkOutput("reset ram_we", 32'(ram_we), 32'd0);
        checkOutput("ram_enable", 32'(ram_enable), 32'd1);
        tick();
        reset = 0;
        applyStimulus(vecs[0]);

        // Initial sweep with both writers already requesting
        for (int i = 0; i < (1 << AW); i++) begin
            #1;
            checkOutput("init busy", 32'(init_busy), 32'd1);
            checkOutput("init we", 32'(ram_we), 32'd1);
            checkOutput("init addr", 32'(ram_wr_addr), 32'(i));
            checkOutput("init data", 32'(ram_wr_data), 32'(INITV));
            checkOutput("init a_wr_ack", 32'(a_wr_ack), 32'd0);
            checkOutput("init b_wr_ack", 32'(b_wr_ack), 32'd0);
            checkOutput("init a_rd_valid", 32'(a_rd_valid), 32'd0);
            tick();
        end
        #1;
        checkOutput("init done", 32'(init_busy), 32'd0);

        for (int k = 0; k < 15; k++) begin
            applyStimulus(vecs[k]);
            #1;
            checkOutput($sformatf("v%0d a_wr_ack", k), 32'(a_wr_ack), 32'(vecs[k].eAwAck));
            checkOutput($sformatf("v%0d b_wr_ack", k), 32'(b_wr_ack), 32'(vecs[k].eBwAck));
            checkOutput($sformatf("v%0d ram_we", k), 32'(ram_we), 32'(vecs[k].eWe));
            if (vecs[k].eWe) begin
                checkOutput($sformatf("v%0d wr_addr", k), 32'(ram_wr_addr), 32'(vecs[k].eWa));
                checkOutput($sformatf("v%0d wr_data", k), 32'(ram_wr_data), 32'(vecs[k].eWd));
            end
            checkOutput($sformatf("v%0d a_rd_ack", k), 32'(a_rd_ack), 32'(vecs[k].eArAck));
            checkOutput($sformatf("v%0d b_rd_ack", k), 32'(b_rd_ack), 32'(vecs[k].eBrAck));
            checkOutput($sformatf("v%0d a_rd_valid", k), 32'(a_rd_valid), 32'(vecs[k].eAv));
            checkOutput($sformatf("v%0d b_rd_valid", k), 32'(b_rd_valid), 32'(vecs[k].eBv));
            if (vecs[k].eAv)
                checkOutput($sformatf("v%0d a_rd_data", k), 32'(a_rd_data), 32'(vecs[k].eRd));
            if (vecs[k].eBv)
                checkOutput($sformatf("v%0d b_rd_data", k), 32'(b_rd_data), 32'(vecs[k].eRd));
            tick();
        end

        // Read acked on N, clear on N+1: the read still completes, then a full re-init
        idleInputs();
        a_rd_req  = 1;
        a_rd_addr = 3;
        #1;
        checkOutput("clr N a_rd_ack", 32'(a_rd_ack), 32'd1);
        tick();
        clear     = 1;
        a_wr_req  = 1;
        a_wr_addr = 3;
        a_wr_data = 8'h99;
        b_rd_req  = 1;
        b_rd_addr = 2;
        #1;
        checkOutput("clr N+1 a_rd_ack", 32'(a_rd_ack), 32'd0);
        checkOutput("clr N+1 b_rd_ack", 32'(b_rd_ack), 32'd0);
        checkOutput("clr N+1 a_wr_ack", 32'(a_wr_ack), 32'd0);
        checkOutput("clr N+1 ram_we", 32'(ram_we), 32'd0);
        checkOutput("clr N+1 a_rd_valid", 32'(a_rd_valid), 32'd1);
        checkOutput("clr N+1 a_rd_data", 32'(a_rd_data), 32'h11);
        checkOutput("clr N+1 init_busy", 32'(init_busy), 32'd0);
        tick();
        clear = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            #1;
            checkOutput("reinit busy", 32'(init_busy), 32'd1);
            checkOutput("reinit a_rd_ack", 32'(a_rd_ack), 32'd0);
            checkOutput("reinit a_wr_ack", 32'(a_wr_ack), 32'd0);
            checkOutput("reinit b_rd_ack", 32'(b_rd_ack), 32'd0);
            checkOutput("reinit a_rd_valid", 32'(a_rd_valid), 32'd0);
            checkOutput("reinit b_rd_valid", 32'(b_rd_valid), 32'd0);
            tick();
        end
        idleInputs();
        #1;
        checkOutput("reinit done", 32'(init_busy), 32'd0);
        readAllInit("after clear");

        // Clear from RUN, then clear again at cnt=7 inside the sweep
        clear = 1;
        #1;
        checkOutput("mid clear ram_we", 32'(ram_we), 32'd0);
        tick();
        busyCycles = 0;
        for (int c = 0; c < 60; c++) begin
            clear = (c == 7);
            #1;
            if (!init_busy) break;
            checkOutput("mid sweep addr", 32'(ram_wr_addr), (c < 8) ? 32'(c) : 32'(c - 8));
            busyCycles++;
            tick();
        end
        clear = 0;
        checkOutput("mid sweep busy cycles", 32'(busyCycles), 32'd24);
        readAllInit("after mid clear");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
